pu_stream_feeder: RTL
=====================

// Module: pu_stream_feeder
// PURPOSE
//  Drives the input side of the 8-MAC processing unit for one output tile.
//  On start_i it reads k_len X-column words and weight bytes from the X/W
//  buffers and streams them on din_o/win_o with valid_o.
//  Generates en_o, the accumulate strobe pu_clear_o, the latch strobe pu_done_o,
//  and a completion pulse done_o. It sits between the buffer banks and the PU.
// PARAMETERS
//  DATA_WIDTH   8  bits per X element
//  WEIGHT_WIDTH 8  bits per weight
//  MAC_NUM      8  X elements per word (PU MAC count)
//  ADDR_WIDTH   4  buffer address width; K_MAX = 2**ADDR_WIDTH
//  MAC_LAT      1  PU MAC latency, in cycles, from valid_i to a usable MAC output
// PORTS
//  clk_i      in  1                     clock; all logic on the rising edge
//  rstn_i     in  1                     reset, asynchronous, active-low
//  start_i    in  1                     tile start request; honoured only in IDLE
//  k_len_i    in  ADDR_WIDTH+1          reduction length; sampled on an accepted start
//  x_rden_o   out 1                     X buffer read enable
//  x_addr_o   out ADDR_WIDTH            X buffer read address
//  x_data_i   in  DATA_WIDTH*MAC_NUM    X buffer data, valid 1 cycle after x_rden_o
//  w_rden_o   out 1                     W buffer read enable
//  w_addr_o   out ADDR_WIDTH            W buffer read address
//  w_data_i   in  WEIGHT_WIDTH          W buffer data, valid 1 cycle after w_rden_o
//  en_o       out 1                     PU enable
//  valid_o    out 1                     PU valid; din_o/win_o are meaningful
//  pu_clear_o out 1                     PU accumulate strobe
//  pu_done_o  out 1                     PU result-latch strobe, 1-cycle pulse
//  din_o      out DATA_WIDTH*MAC_NUM    signed X word to the PU
//  win_o      out WEIGHT_WIDTH          signed weight to the PU
//  busy_o     out 1                     high in any state other than IDLE
//  done_o     out 1                     tile complete, 1-cycle pulse
// BEHAVIOUR
//  Reset: every output is 0, the FSM is in IDLE and all counters are 0.
//   Asserting reset mid-tile aborts the tile with no done_o pulse.
//  FSM states: IDLE -> RUN -> DRAIN -> FIN -> IDLE.
//  IDLE:
//   - start_i=1 with k_len_i!=0: latch K = min(k_len_i, K_MAX) and go to RUN.
//   - start_i=1 with k_len_i==0: pulse done_o on the next cycle and stay in IDLE;
//     no PU strobes and no buffer reads.
//  RUN: for K cycles, x_rden_o = w_rden_o = 1, with x_addr_o = w_addr_o = 0..K-1.
//   After the last read, go to DRAIN.
//  Data path:
//   - Buffer data is registered once.
//   - valid_o/din_o/win_o follow rden by exactly 2 cycles.
//   - din_o and win_o are 0 whenever valid_o is 0.
//  pu_clear_o is valid_o delayed by MAC_LAT cycles, through a shift register.
//  DRAIN: wait until the last pu_clear_o has been issued.
//  FIN:
//   - pu_done_o pulses for 1 cycle, one cycle after the last pu_clear_o.
//   - done_o pulses on the following cycle; the FSM then returns to IDLE.
//  en_o = busy_o, held high from the RUN entry cycle through the done_o cycle.
//  Timing, with start accepted at edge 0 (signal high after edge n):
//   - rden: edges 1..K
//   - valid_o: edges 3..K+2
//   - pu_clear_o: edges 3+MAC_LAT..K+2+MAC_LAT
//   - pu_done_o: edge K+3+MAC_LAT
//   - done_o: edge K+4+MAC_LAT
//  start_i while busy_o=1 is ignored; it is neither queued nor allowed to affect K.
//  A start_i that is high in the same cycle as done_o is ignored;
//   the next accepted start comes at the earliest one cycle later, from IDLE.
//  Address counter: ADDR_WIDTH+1 bits internally.
//   With K = K_MAX the address reaches K_MAX-1 and never wraps to 0 inside a tile.
//  k_len_i > K_MAX is clamped to K_MAX.
// TESTING
//  1. K=4, MAC_LAT=1, X[a]=a+1 per byte, W[a]=2:
//     reads at edges 1-4; valid_o at edges 3-6 with din_o bytes 1..4 and win_o=2;
//     pu_clear_o at edges 4-7; pu_done_o at edge 8; done_o at edge 9.
//  2. k_len_i=0: done_o at edge 1 only; rden, valid_o, pu_clear_o and pu_done_o stay 0.
//  3. k_len_i=31 with ADDR_WIDTH=4: K clamps to 16; addresses run 0..15
//     with no wrap; pu_done_o at edge 20.
//  4. start_i held high for the whole tile plus one cycle:
//     exactly one tile runs and exactly one done_o pulse is produced.
//  5. rstn_i low at edge 5 of a K=8 tile: all outputs are 0 immediately;
//     no done_o; a following start runs a clean full tile.
//  6. Back-to-back tiles, second start 1 cycle after done_o:
//     the second tile's timing is identical to test 1 (relative to its own start).

Source files
------------

// File: rtl/pu_stream_feeder.sv
// -----------------------------------------------------------------------------
// pu_stream_feeder
//   Feeds the input side of the 8-MAC processing unit for one output tile.
//   On an accepted start it reads K X-column words and K weight bytes from the
//   X/W buffers (addresses 0..K-1), registers the returned data once and
//   streams it to the PU on din_o/win_o qualified by valid_o. It also produces
//   the PU accumulate strobe (pu_clear_o), the PU result-latch strobe
//   (pu_done_o) and a tile completion pulse (done_o).
//
// Ports
//   clk_i       clock, rising edge
//   rstn_i      asynchronous active-low reset
//   start_i     tile start request, honoured only in IDLE
//   k_len_i     reduction length, sampled on an accepted start
//   x_rden_o    X buffer read enable
//   x_addr_o    X buffer read address
//   x_data_i    X buffer read data, one cycle after x_rden_o
//   w_rden_o    W buffer read enable
//   w_addr_o    W buffer read address
//   w_data_i    W buffer read data, one cycle after w_rden_o
//   en_o        PU enable (same as busy_o)
//   valid_o     PU valid, din_o/win_o meaningful
//   pu_clear_o  PU accumulate strobe (valid_o delayed by MAC_LAT)
//   pu_done_o   PU result-latch strobe, 1-cycle pulse
//   din_o       X word to the PU
//   win_o       weight to the PU
//   busy_o      high in every state other than IDLE
//   done_o      tile complete, 1-cycle pulse
// -----------------------------------------------------------------------------
module pu_stream_feeder #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned MAC_NUM      = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned MAC_LAT      = 1
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            start_i,
    input  logic [ADDR_WIDTH:0]             k_len_i,
    output logic                            x_rden_o,
    output logic [ADDR_WIDTH-1:0]           x_addr_o,
    input  logic [DATA_WIDTH*MAC_NUM-1:0]   x_data_i,
    output logic                            w_rden_o,
    output logic [ADDR_WIDTH-1:0]           w_addr_o,
    input  logic [WEIGHT_WIDTH-1:0]         w_data_i,
    output logic                            en_o,
    output logic                            valid_o,
    output logic                            pu_clear_o,
    output logic                            pu_done_o,
    output logic [DATA_WIDTH*MAC_NUM-1:0]   din_o,
    output logic [WEIGHT_WIDTH-1:0]         win_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int unsigned         K_MAX_I = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] K_MAX   = K_MAX_I[ADDR_WIDTH:0];
    // every shift-register stage except the one driving pu_clear_o
    localparam logic [MAC_LAT-1:0]  SR_EARLY_MASK = {MAC_LAT{1'b1}} >> 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [ADDR_WIDTH:0]             r_k;
    logic [ADDR_WIDTH:0]             r_cnt;
    logic                            r_rden;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic                            r_rd_d1;
    logic                            r_valid;
    logic [DATA_WIDTH*MAC_NUM-1:0]   r_din;
    logic [WEIGHT_WIDTH-1:0]         r_win;
    logic [MAC_LAT-1:0]              r_clr_sr;
    logic                            r_pu_done;
    logic                            r_done;
    logic                            r_zero_pend;

    logic                            w_accept;
    logic                            w_last_rd;
    logic                            w_last_clr;
    logic                            w_pipe_early;
    logic [ADDR_WIDTH:0]             w_k_clamp;
    logic                            w_rden_nxt;
    logic                            w_pu_done_nxt;
    logic                            w_done_nxt;
    logic                            w_zero_nxt;
    logic                            w_busy;

    // A start is ignored while a zero-length completion is still pending or
    // being signalled, so a start coinciding with done_o is never taken.
    assign w_accept   = (r_state == ST_IDLE) && start_i && !r_done && !r_zero_pend;
    assign w_k_clamp  = (k_len_i > K_MAX) ? K_MAX : k_len_i;
    assign w_last_rd  = (r_cnt == (r_k - 1'b1));

    // Last accumulate strobe is on the PU when pu_clear_o is high and nothing
    // remains further up the read/data/valid/clear pipeline.
    assign w_pipe_early = r_rden || r_rd_d1 || r_valid || (|(r_clr_sr & SR_EARLY_MASK));
    assign w_last_clr   = r_clr_sr[MAC_LAT-1] && !w_pipe_early;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && (k_len_i != '0)) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_rd)                   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_clr)                  w_state_nxt = ST_FIN;
            ST_FIN:   if (r_done)                      w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------- output decode
    always_comb begin
        w_busy        = (r_state != ST_IDLE);
        w_rden_nxt    = (r_state == ST_RUN);
        w_pu_done_nxt = (r_state == ST_DRAIN) && w_last_clr;
        w_zero_nxt    = w_accept && (k_len_i == '0);
        // FIN is entered together with pu_done_o; done_o follows one cycle later
        w_done_nxt    = r_zero_pend || ((r_state == ST_FIN) && r_pu_done);
    end

    // ------------------------------------------------ control registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_k         <= '0;
            r_cnt       <= '0;
            r_rden      <= 1'b0;
            r_addr      <= '0;
            r_pu_done   <= 1'b0;
            r_done      <= 1'b0;
            r_zero_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_k   <= w_k_clamp;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_rden      <= w_rden_nxt;
            r_addr      <= w_rden_nxt ? r_cnt[ADDR_WIDTH-1:0] : '0;
            r_pu_done   <= w_pu_done_nxt;
            r_done      <= w_done_nxt;
            r_zero_pend <= w_zero_nxt;
        end
    end

    // ------------------------------------------------------------ datapath
    // r_rd_d1 marks the cycle in which the buffers present the read data;
    // that data is captured once into din/win together with valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd_d1  <= 1'b0;
            r_valid  <= 1'b0;
            r_din    <= '0;
            r_win    <= '0;
            r_clr_sr <= '0;
        end else begin
            r_rd_d1  <= r_rden;
            r_valid  <= r_rd_d1;
            r_din    <= r_rd_d1 ? x_data_i : '0;
            r_win    <= r_rd_d1 ? w_data_i : '0;
            r_clr_sr <= MAC_LAT'({r_clr_sr, r_valid});
        end
    end

    assign x_rden_o   = r_rden;
    assign w_rden_o   = r_rden;
    assign x_addr_o   = r_addr;
    assign w_addr_o   = r_addr;
    assign valid_o    = r_valid;
    assign din_o      = r_din;
    assign win_o      = r_win;
    assign pu_clear_o = r_clr_sr[MAC_LAT-1];
    assign pu_done_o  = r_pu_done;
    assign done_o     = r_done;
    assign busy_o     = w_busy;
    assign en_o       = w_busy;

endmodule
